// File: rtl/alu_shift_pkg.sv
// Shared types and constants for the iterative shift sequencer/arbiter.
package alu_shift_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned AMT_W  = 6;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  typedef struct packed {
    op_e               op;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
  } req_t;

  // Any amount of DATA_W or more behaves like a full-width shift.
  function automatic logic [AMT_W-1:0] clamp_amount(input logic [DATA_W-1:0] y);
    return (y >= DATA_W) ? AMT_W'(DATA_W) : y[AMT_W-1:0];
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of k positions for the selected op and fill bit.
module shift_step
  import alu_shift_pkg::*;
(
  input  op_e               op_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic              fill_i,
  input  logic [AMT_W-1:0]  k_i,
  output logic [DATA_W-1:0] z_o
);

  logic [2*DATA_W-1:0] ext;

  always_comb begin
    ext = {{DATA_W{fill_i}}, x_i};
    z_o = x_i;
    case (op_i)
      OP_SLL:  z_o = x_i << k_i;
      OP_SRL:  z_o = x_i >> k_i;
      OP_SRA:  z_o = DATA_W'(ext >> k_i);
      default: z_o = x_i;
    endcase
  end

endmodule

// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter for two requesters sharing an iterative shifter
// that moves at most STEP bit positions per cycle.
module shift_unit_arbiter
  import alu_shift_pkg::*;
#(
  parameter int unsigned STEP = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              A_VALID,
  output logic              A_READY,
  input  logic [1:0]        A_OP,
  input  logic [DATA_W-1:0] A_X,
  input  logic [DATA_W-1:0] A_Y,
  input  logic              B_VALID,
  output logic              B_READY,
  input  logic [1:0]        B_OP,
  input  logic [DATA_W-1:0] B_X,
  input  logic [DATA_W-1:0] B_Y,
  output logic              RES_VALID,
  input  logic              RES_READY,
  output logic [DATA_W-1:0] RES_Z,
  output logic              RES_ID
);

  localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] z_q, z_d;
  logic              fill_q, fill_d;
  logic              id_q, id_d;
  logic              last_q, last_d;
  logic [AMT_W-1:0]  rem_q, rem_d;

  logic              idle;
  logic              grant_b;
  req_t              sel_req;
  logic [AMT_W-1:0]  rem_new;
  logic [AMT_W-1:0]  k;
  logic [DATA_W-1:0] step_z;

  // B wins when it is alone or when A held the last grant.
  assign idle    = (state_q == ST_IDLE);
  assign grant_b = B_VALID & (~A_VALID | (last_q == ID_A));
  assign A_READY = rst_n & idle & A_VALID & ~grant_b;
  assign B_READY = rst_n & idle & grant_b;

  always_comb begin
    sel_req.op = op_e'(A_OP);
    sel_req.x  = A_X;
    sel_req.y  = A_Y;
    if (grant_b) begin
      sel_req.op = op_e'(B_OP);
      sel_req.x  = B_X;
      sel_req.y  = B_Y;
    end
  end

  assign rem_new = clamp_amount(sel_req.y);
  assign k       = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;

  shift_step u_shift_step (
    .op_i   (op_q),
    .x_i    (z_q),
    .fill_i (fill_q),
    .k_i    (k),
    .z_o    (step_z)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    z_d     = z_q;
    fill_d  = fill_q;
    id_d    = id_q;
    last_d  = last_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (A_READY | B_READY) begin
          op_d    = sel_req.op;
          z_d     = sel_req.x;
          fill_d  = sel_req.x[DATA_W-1];
          id_d    = grant_b;
          last_d  = grant_b;
          rem_d   = rem_new;
          state_d = (sel_req.op == OP_PASS || rem_new == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        z_d   = step_z;
        rem_d = rem_q - k;
        if (rem_q == k) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (RES_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_SLL;
      z_q     <= '0;
      fill_q  <= 1'b0;
      id_q    <= ID_A;
      last_q  <= ID_B;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      z_q     <= z_d;
      fill_q  <= fill_d;
      id_q    <= id_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
    end
  end

  assign RES_VALID = (state_q == ST_DONE);
  assign RES_Z     = z_q;
  assign RES_ID    = id_q;

endmodule
